dual_fetch: RTL and testbench

DUAL_FETCH -- requirements
Module: dual_fetch

---
 rtl/dual_fetch.sv | 175 +++++++++++++++++
 tb/tb_dual_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_fetch.sv
// dual_fetch: two-wide instruction fetch stage with static jump prediction and
// an optional 16-entry bimodal predictor for conditional branches.
// Optional feature macro: FETCH_BHT_EN (counter table + resolve update logic).
// Without it, conditional branches are predicted not-taken and resolve_* is ignored.
module dual_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [11:0] redirect_pc,
    input  logic [31:0] q_imem_1,
    input  logic [31:0] q_imem_2,
    input  logic        resolve_valid,
    input  logic [11:0] resolve_pc,
    input  logic        resolve_taken,
    output logic [11:0] address_imem_1,
    output logic [11:0] address_imem_2,
    output logic [31:0] fd_t,
    output logic [31:0] fd_b,
    output logic [11:0] fd_pc,
    output logic        fd_valid_t,
    output logic        fd_valid_b,
    output logic        fd_pred_taken
);

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_BLT = 5'b00110;

    function automatic logic is_cond(input logic [31:0] instr);
        return (instr[31:27] == OP_BNE) || (instr[31:27] == OP_BLT);
    endfunction

    function automatic logic is_jump(input logic [31:0] instr);
        return (instr[31:27] == OP_J) || (instr[31:27] == OP_JAL);
    endfunction

    // imm[16:0] truncated to 12 bits only keeps imm[11:0] in a 12-bit sum.
    function automatic logic [11:0] cond_target(input logic [11:0] slot_pc,
                                                input logic [31:0] instr);
        return slot_pc + 12'd1 + instr[11:0];
    endfunction

    function automatic logic [11:0] slot_target(input logic [11:0] slot_pc,
                                                input logic [31:0] instr);
        return is_jump(instr) ? instr[11:0] : cond_target(slot_pc, instr);
    endfunction

    logic [11:0] pc_q, pc_d;
    logic [31:0] fd_t_q, fd_t_d;
    logic [31:0] fd_b_q, fd_b_d;
    logic [11:0] fd_pc_q, fd_pc_d;
    logic        fd_valid_t_q, fd_valid_t_d;
    logic        fd_valid_b_q, fd_valid_b_d;
    logic        fd_pred_taken_q, fd_pred_taken_d;

    logic [11:0] pc_plus1;
    logic [11:0] pc_plus2;
    logic        top_cnt_taken;
    logic        bot_cnt_taken;
    logic        top_taken;
    logic        bot_taken;

    assign pc_plus1 = pc_q + 12'd1;
    assign pc_plus2 = pc_q + 12'd2;

`ifdef FETCH_BHT_EN
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    logic [1:0] bht_q [16];
    logic [1:0] bht_d [16];
    logic       unused_resolve_hi;

    assign unused_resolve_hi = ^resolve_pc[11:4];

    // Counter training from the execute-stage resolve port; independent of stall/flush.
    always_comb begin
        bht_d = bht_q;
        if (resolve_valid) begin
            bht_d[resolve_pc[3:0]] = sat_update(bht_q[resolve_pc[3:0]], resolve_taken);
        end
    end

    // Counter table storage; lookups below read the registered (pre-update) value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end

    assign top_cnt_taken = bht_q[pc_q[3:0]][1];
    assign bot_cnt_taken = bht_q[pc_plus1[3:0]][1];
`else
    logic unused_resolve;

    assign unused_resolve = ^{resolve_valid, resolve_pc, resolve_taken};
    assign top_cnt_taken  = 1'b0;
    assign bot_cnt_taken  = 1'b0;
`endif

    assign top_taken = is_jump(q_imem_1) || (is_cond(q_imem_1) && top_cnt_taken);
    assign bot_taken = is_jump(q_imem_2) || (is_cond(q_imem_2) && bot_cnt_taken);

    // Next-PC selection and fetch/decode register capture; flush outranks stall.
    always_comb begin
        pc_d            = pc_q;
        fd_t_d          = fd_t_q;
        fd_b_d          = fd_b_q;
        fd_pc_d         = fd_pc_q;
        fd_valid_t_d    = fd_valid_t_q;
        fd_valid_b_d    = fd_valid_b_q;
        fd_pred_taken_d = fd_pred_taken_q;
        if (flush) begin
            pc_d            = redirect_pc;
            fd_valid_t_d    = 1'b0;
            fd_valid_b_d    = 1'b0;
            fd_pred_taken_d = 1'b0;
        end else if (!stall) begin
            fd_t_d       = q_imem_1;
            fd_b_d       = q_imem_2;
            fd_pc_d      = pc_q;
            fd_valid_t_d = 1'b1;
            if (top_taken) begin
                pc_d            = slot_target(pc_q, q_imem_1);
                fd_valid_b_d    = 1'b0;
                fd_pred_taken_d = 1'b1;
            end else if (bot_taken) begin
                pc_d            = slot_target(pc_plus1, q_imem_2);
                fd_valid_b_d    = 1'b1;
                fd_pred_taken_d = 1'b1;
            end else begin
                pc_d            = pc_plus2;
                fd_valid_b_d    = 1'b1;
                fd_pred_taken_d = 1'b0;
            end
        end
    end

    // PC and fetch/decode pipeline registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q            <= 12'd0;
            fd_t_q          <= 32'd0;
            fd_b_q          <= 32'd0;
            fd_pc_q         <= 12'd0;
            fd_valid_t_q    <= 1'b0;
            fd_valid_b_q    <= 1'b0;
            fd_pred_taken_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            fd_t_q          <= fd_t_d;
            fd_b_q          <= fd_b_d;
            fd_pc_q         <= fd_pc_d;
            fd_valid_t_q    <= fd_valid_t_d;
            fd_valid_b_q    <= fd_valid_b_d;
            fd_pred_taken_q <= fd_pred_taken_d;
        end
    end

    assign address_imem_1 = pc_q;
    assign address_imem_2 = pc_plus1;
    assign fd_t           = fd_t_q;
    assign fd_b           = fd_b_q;
    assign fd_pc          = fd_pc_q;
    assign fd_valid_t     = fd_valid_t_q;
    assign fd_valid_b     = fd_valid_b_q;
    assign fd_pred_taken  = fd_pred_taken_q;

endmodule

// File: tb/tb_dual_fetch.sv
// tb_dual_fetch: directed and randomized checks of dual_fetch against a
// behavioural fetch model. Honours FETCH_BHT_EN the same way as the design.
module tb_dual_fetch;

`ifdef FETCH_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [11:0] redirect_pc;
    logic [31:0] q_imem_1;
    logic [31:0] q_imem_2;
    logic        resolve_valid;
    logic [11:0] resolve_pc;
    logic        resolve_taken;
    logic [11:0] address_imem_1;
    logic [11:0] address_imem_2;
    logic [31:0] fd_t;
    logic [31:0] fd_b;
    logic [11:0] fd_pc;
    logic        fd_valid_t;
    logic        fd_valid_b;
    logic        fd_pred_taken;

    logic [31:0] imem [4096];
    logic [102:0] dut_outs;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    int          m_pc;
    logic [31:0] m_fd_t;
    logic [31:0] m_fd_b;
    int          m_fd_pc;
    bit          m_vt, m_vb, m_pt;
    int          m_cnt [16];

    dual_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .q_imem_1       (q_imem_1),
        .q_imem_2       (q_imem_2),
        .resolve_valid  (resolve_valid),
        .resolve_pc     (resolve_pc),
        .resolve_taken  (resolve_taken),
        .address_imem_1 (address_imem_1),
        .address_imem_2 (address_imem_2),
        .fd_t           (fd_t),
        .fd_b           (fd_b),
        .fd_pc          (fd_pc),
        .fd_valid_t     (fd_valid_t),
        .fd_valid_b     (fd_valid_b),
        .fd_pred_taken  (fd_pred_taken)
    );

    assign q_imem_1 = imem[address_imem_1];
    assign q_imem_2 = imem[address_imem_2];
    assign dut_outs = {address_imem_1, address_imem_2, fd_t, fd_b, fd_pc,
                       fd_valid_t, fd_valid_b, fd_pred_taken};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [102:0] RESET_OUTS = {12'd0, 12'd1, 32'd0, 32'd0, 12'd0, 3'b000};

    function automatic logic [102:0] exp_outs();
        return {12'(m_pc), 12'((m_pc + 1) % 4096), m_fd_t, m_fd_b, 12'(m_fd_pc),
                m_vt, m_vb, m_pt};
    endfunction

    function automatic logic [31:0] mk_instr(input int op, input int low17);
        logic [31:0] w;
        w        = 32'd0;
        w[31:27] = 5'(op);
        w[16:0]  = 17'(low17);
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          op;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: op = 0;
            1: op = 2;
            2: op = 6;
            3: op = 1;
            4: op = 3;
            default: op = 9;
        endcase
        w[31:27] = 5'(op);
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_fd_t = 0; m_fd_b = 0; m_fd_pc = 0;
        m_vt = 0; m_vb = 0; m_pt = 0;
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
    endtask

    task automatic predict(input logic [31:0] w, input int spc, output bit tk, output int tgt);
        int op;
        op  = int'(w[31:27]);
        tk  = 0;
        tgt = 0;
        if (op == 1 || op == 3) begin
            tk  = 1;
            tgt = int'(w[11:0]);
        end else if (op == 2 || op == 6) begin
            tk  = BHT && (m_cnt[spc % 16] >= 2);
            tgt = (spc + 1 + int'(w[16:0])) % 4096;
        end
    endtask

    task automatic model_step(input bit st, input bit fl, input int rd,
                              input bit rv, input int rp, input bit rt);
        int          pcb, tt_tgt, bt_tgt, idx;
        bit          tt, bt;
        logic [31:0] it, ib;
        pcb = (m_pc + 1) % 4096;
        it  = imem[m_pc];
        ib  = imem[pcb];
        predict(it, m_pc, tt, tt_tgt);
        predict(ib, pcb, bt, bt_tgt);
        if (fl) begin
            m_pc = rd % 4096; m_vt = 0; m_vb = 0; m_pt = 0;
        end else if (!st) begin
            m_fd_t = it; m_fd_b = ib; m_fd_pc = m_pc; m_vt = 1;
            if (tt) begin
                m_vb = 0; m_pt = 1; m_pc = tt_tgt;
            end else if (bt) begin
                m_vb = 1; m_pt = 1; m_pc = bt_tgt;
            end else begin
                m_vb = 1; m_pt = 0; m_pc = (m_pc + 2) % 4096;
            end
        end
        if (BHT && rv) begin
            idx = rp % 16;
            if (rt) begin
                if (m_cnt[idx] < 3) m_cnt[idx]++;
            end else begin
                if (m_cnt[idx] > 0) m_cnt[idx]--;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
    task automatic step(input bit st, input bit fl, input int rd,
                        input bit rv, input int rp, input bit rt);
        stall         = st;
        flush         = fl;
        redirect_pc   = 12'(rd);
        resolve_valid = rv;
        resolve_pc    = 12'(rp);
        resolve_taken = rt;
        model_step(st, fl, rd, rv, rp, rt);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 0; flush = 0; redirect_pc = 0;
        resolve_valid = 0; resolve_pc = 0; resolve_taken = 0;
        for (int i = 0; i < 4096; i++) imem[i] = 32'd0;
        model_reset();
        #2;
        tests++;
        if (dut_outs !== RESET_OUTS) begin
            $display("FAIL reset_async got=%h exp=%h", dut_outs, RESET_OUTS); fails++;
        end
        @(posedge clock); #1;
        tests++;
        if (dut_outs !== RESET_OUTS) begin
            $display("FAIL reset_held got=%h exp=%h", dut_outs, RESET_OUTS); fails++;
        end
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        imem[0] = mk_instr(0, 7);
        imem[1] = mk_instr(0, 9);
        tests++;
        if ({address_imem_1, address_imem_2} !== {12'd0, 12'd1}) begin
            $display("FAIL seq_first_addr got=%h/%h exp=000/001", address_imem_1, address_imem_2); fails++;
        end
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if ({address_imem_1, address_imem_2, fd_pc, fd_valid_t, fd_valid_b, fd_pred_taken}
            !== {12'd2, 12'd3, 12'd0, 3'b110}) begin
            $display("FAIL seq_next got=%h/%h pc=%h v=%b%b p=%b exp=002/003 pc=000 v=11 p=0",
                     address_imem_1, address_imem_2, fd_pc, fd_valid_t, fd_valid_b, fd_pred_taken);
            fails++;
        end
        tests++;
        if (dut_outs !== exp_outs()) begin
            $display("FAIL seq_model got=%h exp=%h", dut_outs, exp_outs()); fails++;
        end
    endtask

    task automatic test_jump();
        step(0, 1, 4, 0, 0, 0);
        imem[4] = mk_instr(1, 12'h020);
        imem[5] = mk_instr(0, 0);
        tests++;
        if (address_imem_1 !== 12'd4 || fd_valid_t !== 1'b0) begin
            $display("FAIL jump_redirect got=%h vt=%b exp=004 vt=0", address_imem_1, fd_valid_t); fails++;
        end
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if ({address_imem_1, address_imem_2, fd_pc, fd_valid_t, fd_valid_b, fd_pred_taken}
            !== {12'h020, 12'h021, 12'd4, 3'b101}) begin
            $display("FAIL jump_top got=%h/%h pc=%h v=%b%b p=%b exp=020/021 pc=004 v=10 p=1",
                     address_imem_1, address_imem_2, fd_pc, fd_valid_t, fd_valid_b, fd_pred_taken);
            fails++;
        end
        tests++;
        if (dut_outs !== exp_outs()) begin
            $display("FAIL jump_model got=%h exp=%h", dut_outs, exp_outs()); fails++;
        end
    endtask

    task automatic test_bht();
        logic [11:0] want;
        want = BHT ? 12'd14 : 12'd9;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 8, 1);
        imem[7] = mk_instr(0, 0);
        imem[8] = mk_instr(2, 5);
        step(0, 1, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (address_imem_1 !== want || fd_pred_taken !== BHT || fd_valid_b !== 1'b1) begin
            $display("FAIL bht_bottom got=%h p=%b vb=%b exp=%h p=%b vb=1",
                     address_imem_1, fd_pred_taken, fd_valid_b, want, BHT);
            fails++;
        end
        tests++;
        if (dut_outs !== exp_outs()) begin
            $display("FAIL bht_model got=%h exp=%h", dut_outs, exp_outs()); fails++;
        end
    endtask

    task automatic test_stall_flush();
        step(1, 0, 0, 0, 0, 0);
        tests++;
        if (dut_outs !== exp_outs()) begin
            $display("FAIL stall_hold got=%h exp=%h", dut_outs, exp_outs()); fails++;
        end
        step(1, 1, 12'h100, 0, 0, 0);
        tests++;
        if ({address_imem_1, fd_valid_t, fd_valid_b, fd_pred_taken} !== {12'h100, 3'b000}) begin
            $display("FAIL stall_flush got=%h v=%b%b p=%b exp=100 v=00 p=0",
                     address_imem_1, fd_valid_t, fd_valid_b, fd_pred_taken);
            fails++;
        end
    endtask

    task automatic test_wrap();
        imem[4094] = mk_instr(0, 0);
        imem[4095] = mk_instr(0, 0);
        step(0, 1, 4094, 0, 0, 0);
        tests++;
        if ({address_imem_1, address_imem_2} !== {12'd4094, 12'd4095}) begin
            $display("FAIL wrap_addr got=%h/%h exp=ffe/fff", address_imem_1, address_imem_2); fails++;
        end
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if ({address_imem_1, address_imem_2, fd_pc} !== {12'd0, 12'd1, 12'd4094}) begin
            $display("FAIL wrap_next got=%h/%h pc=%h exp=000/001 pc=ffe",
                     address_imem_1, address_imem_2, fd_pc);
            fails++;
        end
    endtask

    task automatic test_random();
        bit st, fl, rv, rt;
        int rd, rp;
        for (int i = 0; i < 4096; i++) imem[i] = rand_instr();
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            rv = ($urandom_range(0, 1) == 0);
            rt = ($urandom_range(0, 1) == 0);
            rd = $urandom_range(0, 4095);
            rp = $urandom_range(0, 4095);
            step(st, fl, rd, rv, rp, rt);
            tests++;
            if (dut_outs !== exp_outs()) begin
                $display("FAIL random_cycle%0d got=%h exp=%h", n, dut_outs, exp_outs()); fails++;
            end
        end
    endtask

    task automatic test_reset_mid();
        imem[0] = mk_instr(2, 5);
        imem[1] = mk_instr(0, 0);
        step(0, 1, 100, 1, 0, 1);
        step(1, 0, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        tests++;
        if (dut_outs !== RESET_OUTS) begin
            $display("FAIL reset_mid_async got=%h exp=%h", dut_outs, RESET_OUTS); fails++;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if ({address_imem_1, fd_pred_taken, fd_valid_b} !== {12'd2, 2'b01}) begin
            $display("FAIL reset_mid_counters got=%h p=%b vb=%b exp=002 p=0 vb=1",
                     address_imem_1, fd_pred_taken, fd_valid_b);
            fails++;
        end
        tests++;
        if (dut_outs !== exp_outs()) begin
            $display("FAIL reset_mid_model got=%h exp=%h", dut_outs, exp_outs()); fails++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_bht();
        test_stall_flush();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
